// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: 3-5 cycles per instruction, 2 for an illegal one.
// Backpressure: IF, MRD and MWR hold while mem_ready is low (when WAIT_MEM = 1).
module multicycle_controller #(
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcld,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] regdst,
    output logic [1:0] wbsrc,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic [1:0] pcsrc,
    output logic       done,
    output logic       illegal
);

    localparam logic [3:0] S_IF   = 4'd0;
    localparam logic [3:0] S_ID   = 4'd1;
    localparam logic [3:0] S_MADR = 4'd2;
    localparam logic [3:0] S_MRD  = 4'd3;
    localparam logic [3:0] S_MWB  = 4'd4;
    localparam logic [3:0] S_MWR  = 4'd5;
    localparam logic [3:0] S_REX  = 4'd6;
    localparam logic [3:0] S_RWB  = 4'd7;
    localparam logic [3:0] S_IEX  = 4'd8;
    localparam logic [3:0] S_IWB  = 4'd9;
    localparam logic [3:0] S_BR   = 4'd10;
    localparam logic [3:0] S_JMP  = 4'd11;
    localparam logic [3:0] S_JAL  = 4'd12;
    localparam logic [3:0] S_JR   = 4'd13;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    logic [3:0] state;
    logic [3:0] next_state;
    logic       mem_ok;
    logic [2:0] r_aluop;
    logic       r_legal;
    logic [2:0] i_aluop;

    assign mem_ok = mem_ready | ~WAIT_MEM;

    // func is decoded straight into the ALU opcode; jr is legal but uses no ALU op.
    always_comb begin
        r_aluop = ALU_ADD;
        r_legal = 1'b1;
        case (func)
            F_ADD:   r_aluop = ALU_ADD;
            F_SUB:   r_aluop = ALU_SUB;
            F_AND:   r_aluop = ALU_AND;
            F_OR:    r_aluop = ALU_OR;
            F_SLT:   r_aluop = ALU_SLT;
            F_JR:    r_aluop = ALU_ADD;
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_SLTI: i_aluop = ALU_SLT;
            OP_ANDI: i_aluop = ALU_AND;
            default: i_aluop = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IF;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IF: begin
                if (mem_ok) begin
                    next_state = S_ID;
                end
            end
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW:              next_state = S_MADR;
                    OP_R: begin
                        if (!r_legal) begin
                            next_state = S_IF;
                        end else if (func == F_JR) begin
                            next_state = S_JR;
                        end else begin
                            next_state = S_REX;
                        end
                    end
                    OP_BEQ, OP_BNE:            next_state = S_BR;
                    OP_ADDI, OP_SLTI, OP_ANDI: next_state = S_IEX;
                    OP_J:                      next_state = S_JMP;
                    OP_JAL:                    next_state = S_JAL;
                    default:                   next_state = S_IF;
                endcase
            end
            S_MADR:  next_state = (opcode == OP_SW) ? S_MWR : S_MRD;
            S_MRD:   next_state = mem_ok ? S_MWB : S_MRD;
            S_MWR:   next_state = mem_ok ? S_IF : S_MWR;
            S_REX:   next_state = S_RWB;
            S_IEX:   next_state = S_IWB;
            default: next_state = S_IF;
        endcase
    end

    // Outputs are forced to zero for as long as rst is held low, independent of the clock.
    always_comb begin
        pcld     = 1'b0;
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 2'b00;
        wbsrc    = 2'b00;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = ALU_ADD;
        pcsrc    = 2'b00;
        done     = 1'b0;
        illegal  = 1'b0;
        if (rst) begin
            case (state)
                S_IF: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ok;
                    pcld    = mem_ok;
                end
                S_ID: begin
                    alusrcb = 2'b11;
                    if (next_state == S_IF) begin
                        illegal = 1'b1;
                        done    = 1'b1;
                    end
                end
                S_MADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MWB: begin
                    regwrite = 1'b1;
                    wbsrc    = 2'b01;
                    done     = 1'b1;
                end
                S_MWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                    done     = mem_ok;
                end
                S_REX: begin
                    alusrca = 1'b1;
                    aluop   = r_aluop;
                end
                S_RWB: begin
                    regwrite = 1'b1;
                    regdst   = 2'b01;
                    done     = 1'b1;
                end
                S_IEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop   = i_aluop;
                end
                S_IWB: begin
                    regwrite = 1'b1;
                    done     = 1'b1;
                end
                S_BR: begin
                    alusrca = 1'b1;
                    aluop   = ALU_SUB;
                    pcsrc   = 2'b01;
                    pcld    = (opcode == OP_BNE) ? ~zero : zero;
                    done    = 1'b1;
                end
                S_JMP: begin
                    pcsrc = 2'b10;
                    pcld  = 1'b1;
                    done  = 1'b1;
                end
                // PC still holds PC+4 here, so wbsrc = PC writes the return address.
                S_JAL: begin
                    pcsrc    = 2'b10;
                    pcld     = 1'b1;
                    regwrite = 1'b1;
                    regdst   = 2'b10;
                    wbsrc    = 2'b10;
                    done     = 1'b1;
                end
                S_JR: begin
                    pcsrc = 2'b11;
                    pcld  = 1'b1;
                    done  = 1'b1;
                end
                default: begin
                    pcld = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction expected control sequences
// are generated from the instruction's class and compared cycle by cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pcld, iord, memread, memwrite, irwrite, regwrite, alusrca, done, illegal;
    logic [1:0] regdst, wbsrc, alusrcb, pcsrc;
    logic [2:0] aluop;

    typedef struct packed {
        logic       pcld;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] regdst;
        logic [1:0] wbsrc;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       done;
        logic       illegal;
    } ctl_t;

    localparam int C_ILL = 0, C_LW = 1, C_SW = 2, C_R = 3, C_JR = 4, C_BEQ = 5;
    localparam int C_BNE = 6, C_I = 7, C_J = 8, C_JAL = 9;

    int   total = 0;
    int   bad = 0;
    ctl_t exp_q[$];
    bit   mr_q[$];
    bit   z_q[$];

    logic [5:0] leg_op [15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2b,
                                6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c, 6'h02, 6'h03};
    logic [5:0] leg_fn [15] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    multicycle_controller #(.WAIT_MEM(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pcld(pcld), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .wbsrc(wbsrc),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsrc(pcsrc), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t obs();
        return '{pcld, iord, memread, memwrite, irwrite, regdst, wbsrc, regwrite,
                 alusrca, alusrcb, aluop, pcsrc, done, illegal};
    endfunction

    function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h08) return C_JR;
                if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) return C_R;
                return C_ILL;
            end
            6'h23: return C_LW;
            6'h2b: return C_SW;
            6'h04: return C_BEQ;
            6'h05: return C_BNE;
            6'h08, 6'h0a, 6'h0c: return C_I;
            6'h02: return C_J;
            6'h03: return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    // ALU operation the instruction asks for: add/sub/and/or/slt -> 0..4.
    function automatic logic [2:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h0a) return 3'd4;
        if (op == 6'h0c) return 3'd2;
        if (op != 6'h00) return 3'd0;
        case (fn)
            6'h22: return 3'd1;
            6'h24: return 3'd2;
            6'h25: return 3'd3;
            6'h2a: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    task automatic push(input ctl_t v, input bit mr, input bit z);
        exp_q.push_back(v);
        mr_q.push_back(mr);
        z_q.push_back(z);
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int ifw,
                         input int mw, input int zsel);
        ctl_t v;
        int   c;
        bit   z;
        exp_q.delete();
        mr_q.delete();
        z_q.delete();
        for (int i = 0; i <= ifw; i++) begin
            v = '0; v.memread = 1; v.alusrcb = 2'b01;
            v.irwrite = (i == ifw); v.pcld = (i == ifw);
            push(v, i == ifw, 1'($urandom));
        end
        c = cls(op, fn);
        v = '0; v.alusrcb = 2'b11;
        if (c == C_ILL) begin v.illegal = 1; v.done = 1; end
        push(v, 1'($urandom), 1'($urandom));
        v = '0;
        case (c)
            C_LW, C_SW: begin
                v.alusrca = 1; v.alusrcb = 2'b10;
                push(v, 1'($urandom), 1'($urandom));
                for (int i = 0; i <= mw; i++) begin
                    v = '0; v.iord = 1;
                    if (c == C_LW) v.memread = 1;
                    else begin v.memwrite = 1; v.done = (i == mw); end
                    push(v, i == mw, 1'($urandom));
                end
                if (c == C_LW) begin
                    v = '0; v.regwrite = 1; v.wbsrc = 2'b01; v.done = 1;
                    push(v, 1'($urandom), 1'($urandom));
                end
            end
            C_R, C_I: begin
                v.alusrca = 1; v.aluop = alu_of(op, fn);
                if (c == C_I) v.alusrcb = 2'b10;
                push(v, 1'($urandom), 1'($urandom));
                v = '0; v.regwrite = 1; v.done = 1;
                if (c == C_R) v.regdst = 2'b01;
                push(v, 1'($urandom), 1'($urandom));
            end
            C_BEQ, C_BNE: begin
                z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
                v.alusrca = 1; v.aluop = 3'd1; v.pcsrc = 2'b01; v.done = 1;
                v.pcld = (c == C_BEQ) ? z : ~z;
                push(v, 1'($urandom), z);
            end
            C_J, C_JAL, C_JR: begin
                v.pcld = 1; v.done = 1;
                v.pcsrc = (c == C_JR) ? 2'b11 : 2'b10;
                if (c == C_JAL) begin v.regwrite = 1; v.regdst = 2'b10; v.wbsrc = 2'b10; end
                push(v, 1'($urandom), 1'($urandom));
            end
            default: ;
        endcase
    endtask

    // Entered and left just after a rising edge; runs at most lim cycles of the plan.
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input int ifw, input int mw, input int zsel, input int lim);
        build(op, fn, ifw, mw, zsel);
        opcode = op;
        func = fn;
        for (int k = 0; k < exp_q.size() && k < lim; k++) begin
            mem_ready = mr_q[k];
            zero = z_q[k];
            @(negedge clk);
            chk($sformatf("%s_c%0d", name, k), 32'(obs()), 32'(exp_q[k]));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int r;
        int ifw;
        int mw;
        logic [5:0] op;
        logic [5:0] fn;
        rst = 1'b0;
        repeat (3) begin
            mem_ready = 1'b1;
            opcode = 6'($urandom);
            @(negedge clk);
            chk("rst_hold", 32'(obs()), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        run("sub", 6'h00, 6'h22, 0, 0, -1, 99);
        run("lw_wait", 6'h23, 6'h00, 0, 2, -1, 99);
        run("beq_z1", 6'h04, 6'h00, 0, 0, 1, 99);
        run("bne_z1", 6'h05, 6'h00, 1, 0, 1, 99);
        run("jal", 6'h03, 6'h00, 0, 0, -1, 99);
        run("ill", 6'h3f, 6'h00, 0, 0, -1, 99);
        run("jr", 6'h00, 6'h08, 0, 0, -1, 99);
        run("ill_fn", 6'h00, 6'h3f, 0, 0, -1, 99);
        // sw abandoned by reset while MWR waits on memory.
        run("sw_cut", 6'h2b, 6'h00, 0, 3, -1, 4);
        mem_ready = 1'b0;
        #2;
        chk("mwr_memwrite", 32'(memwrite), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_async_memwrite", 32'(memwrite), 32'd0);
        chk("rst_async_all", 32'(obs()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold2", 32'(obs()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run("restart", 6'h08, 6'h00, 0, 0, -1, 99);
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                r = $urandom_range(0, 14);
                op = leg_op[r];
                fn = leg_fn[r];
            end
            ifw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            run($sformatf("rnd%0d_op%h", n, op), op, fn, ifw, mw, -1, 99);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
